// File: rtl/x68_ioctl_loader_bridge.sv
// x68_ioctl_loader_bridge
// Bridges the hps_io ioctl download byte stream to the X68000 core loaders.
// Bytes are packed big-endian into DW-bit words (lane 0 = MSB byte), each
// download is steered to one of NCH loader channels by ioctl_index, and every
// word is delivered over a level ldr_wr / edge-sensitive ldr_ack handshake
// while ioctl_wait holds the HPS off.
//
// Ports
//   clk_sys, reset      : clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout : hps_io download interface (inputs)
//   ioctl_wait          : hold-off back to hps_io
//   ldr_aen             : one-hot channel enable for the running download
//   ldr_addr/wdat/be/wr : word write request towards the core
//   ldr_ack             : core acknowledge, its rising edge completes a write
//   ldr_done            : sticky per-channel completion flags
//   ldr_ovf             : sticky flag, a byte was lost while stalled
module x68_ioctl_loader_bridge #(
    parameter int DW       = 16,
    parameter int AW       = 20,
    parameter int NCH      = 2,
    parameter int IDX_BASE = 0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [NCH-1:0]    ldr_aen,
    output logic [AW-1:0]     ldr_addr,
    output logic [DW-1:0]     ldr_wdat,
    output logic [DW/8-1:0]   ldr_be,
    output logic              ldr_wr,
    input  logic              ldr_ack,
    output logic [NCH-1:0]    ldr_done,
    output logic              ldr_ovf
);

    localparam int NB = DW / 8;
    localparam int L  = $clog2(NB);
    localparam int LW = (L > 0) ? L : 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_REQ, S_FINI} state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_ch, w_ch_next;
    logic [NCH-1:0]  r_aen, w_aen_next;
    logic [AW-1:0]   r_addr, w_addr_next;
    logic [DW-1:0]   r_wdat, w_wdat_next;
    logic [NB-1:0]   r_be, w_be_next;
    logic            r_wr, w_wr_next;
    logic            r_wait, w_wait_next;
    logic [NCH-1:0]  r_done, w_done_next;
    logic            r_ovf, w_ovf_next;
    logic            r_end, w_end_next;     // download window has closed
    logic            r_skid_v, w_skid_v_next;
    logic [LW-1:0]   r_skid_lane, w_skid_lane_next;
    logic [7:0]      r_skid_dat, w_skid_dat_next;
    logic [AW-1:0]   r_skid_addr, w_skid_addr_next;
    logic            r_ack_q, r_dl_q;

    logic [LW-1:0]   w_lane;
    logic [AW-1:0]   w_waddr;
    logic            w_last, w_ack_rise, w_dl_rise, w_accept, w_ended;
    int              w_ch_int;
    logic [CW-1:0]   w_ch;

    // With byte-wide words there is only one lane
    generate
        if (NB == 1) begin : g_lane_single
            assign w_lane = '0;
        end else begin : g_lane_multi
            assign w_lane = ioctl_addr[LW-1:0];
        end
    endgenerate

    assign w_waddr    = AW'(ioctl_addr >> L);
    assign w_last     = (w_lane == LW'(NB - 1));
    assign w_ack_rise = ldr_ack & ~r_ack_q;
    assign w_dl_rise  = ioctl_download & ~r_dl_q;
    assign w_ch_int   = int'(ioctl_index) - IDX_BASE;
    assign w_ch       = w_ch_int[CW-1:0];
    assign w_accept   = (w_ch_int >= 0) && (w_ch_int < NCH) && !r_done[w_ch];
    assign w_ended    = ~ioctl_download | r_end;

    // Drop one byte into its big-endian lane and flag the matching enable
    function automatic logic [DW+NB-1:0] f_put(input logic [DW-1:0] wd,
                                               input logic [NB-1:0] be,
                                               input logic [LW-1:0] lane,
                                               input logic [7:0]    d);
        logic [DW-1:0] nwd;
        logic [NB-1:0] nbe;
        nwd = wd;
        nbe = be;
        for (int k = 0; k < NB; k++) begin
            if (lane == LW'(k)) begin
                nwd[(NB-1-k)*8 +: 8] = d;
                nbe[NB-1-k]          = 1'b1;
            end
        end
        return {nwd, nbe};
    endfunction

    always_comb begin
        w_state_next     = r_state;
        w_ch_next        = r_ch;
        w_aen_next       = r_aen;
        w_addr_next      = r_addr;
        w_wdat_next      = r_wdat;
        w_be_next        = r_be;
        w_wr_next        = r_wr;
        w_wait_next      = r_wait;
        w_done_next      = r_done;
        w_ovf_next       = r_ovf;
        w_end_next       = r_end;
        w_skid_v_next    = r_skid_v;
        w_skid_lane_next = r_skid_lane;
        w_skid_dat_next  = r_skid_dat;
        w_skid_addr_next = r_skid_addr;

        if ((r_state == S_FILL || r_state == S_REQ) && !ioctl_download)
            w_end_next = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_end_next = 1'b0;
                if (w_dl_rise && w_accept) begin
                    w_state_next = S_FILL;
                    w_ch_next    = w_ch;
                    w_aen_next   = NCH'(1) << w_ch;
                end
            end
            S_FILL: begin
                if (r_be[0]) begin
                    // Word completed by a replayed skid byte: issue it now
                    w_state_next = S_REQ;
                    w_wr_next    = 1'b1;
                    w_wait_next  = 1'b1;
                    if (ioctl_wr) begin
                        w_skid_v_next    = 1'b1;
                        w_skid_lane_next = w_lane;
                        w_skid_dat_next  = ioctl_dout;
                        w_skid_addr_next = w_waddr;
                    end
                end else if (ioctl_wr) begin
                    if (r_be != '0 && w_waddr != r_addr) begin
                        // Jump to a new word: flush the partial one, park the byte
                        w_state_next     = S_REQ;
                        w_wr_next        = 1'b1;
                        w_wait_next      = 1'b1;
                        w_skid_v_next    = 1'b1;
                        w_skid_lane_next = w_lane;
                        w_skid_dat_next  = ioctl_dout;
                        w_skid_addr_next = w_waddr;
                    end else begin
                        {w_wdat_next, w_be_next} = f_put(r_wdat, r_be, w_lane, ioctl_dout);
                        if (r_be == '0)
                            w_addr_next = w_waddr;
                        if (w_last) begin
                            w_state_next = S_REQ;
                            w_wr_next    = 1'b1;
                            w_wait_next  = 1'b1;
                        end
                    end
                end else if (w_ended) begin
                    if (r_be != '0) begin
                        w_state_next = S_REQ;
                        w_wr_next    = 1'b1;
                        w_wait_next  = 1'b1;
                    end else begin
                        w_state_next = S_FINI;
                    end
                end
            end
            S_REQ: begin
                if (w_ack_rise) begin
                    w_wr_next     = 1'b0;
                    w_skid_v_next = 1'b0;
                    if (ioctl_wr && r_skid_v)
                        w_ovf_next = 1'b1;
                    if (r_skid_v) begin
                        {w_wdat_next, w_be_next} = f_put('0, '0, r_skid_lane, r_skid_dat);
                        w_addr_next  = r_skid_addr;
                        w_state_next = S_FILL;
                        // Stay stalled if the replayed byte already fills the word
                        w_wait_next  = (r_skid_lane == LW'(NB - 1));
                    end else if (ioctl_wr) begin
                        {w_wdat_next, w_be_next} = f_put('0, '0, w_lane, ioctl_dout);
                        w_addr_next  = w_waddr;
                        w_state_next = S_FILL;
                        w_wait_next  = w_last;
                    end else begin
                        w_wdat_next  = '0;
                        w_be_next    = '0;
                        w_wait_next  = 1'b0;
                        w_state_next = w_ended ? S_FINI : S_FILL;
                    end
                end else if (ioctl_wr) begin
                    if (r_skid_v) begin
                        w_ovf_next = 1'b1;
                    end else begin
                        w_skid_v_next    = 1'b1;
                        w_skid_lane_next = w_lane;
                        w_skid_dat_next  = ioctl_dout;
                        w_skid_addr_next = w_waddr;
                    end
                end
            end
            S_FINI: begin
                w_done_next[r_ch] = 1'b1;
                w_aen_next        = '0;
                w_state_next      = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_aen       <= '0;
            r_addr      <= '0;
            r_wdat      <= '0;
            r_be        <= '0;
            r_wr        <= 1'b0;
            r_wait      <= 1'b0;
            r_done      <= '0;
            r_ovf       <= 1'b0;
            r_end       <= 1'b0;
            r_skid_v    <= 1'b0;
            r_skid_lane <= '0;
            r_skid_dat  <= '0;
            r_skid_addr <= '0;
            r_ack_q     <= 1'b0;
            r_dl_q      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ch        <= w_ch_next;
            r_aen       <= w_aen_next;
            r_addr      <= w_addr_next;
            r_wdat      <= w_wdat_next;
            r_be        <= w_be_next;
            r_wr        <= w_wr_next;
            r_wait      <= w_wait_next;
            r_done      <= w_done_next;
            r_ovf       <= w_ovf_next;
            r_end       <= w_end_next;
            r_skid_v    <= w_skid_v_next;
            r_skid_lane <= w_skid_lane_next;
            r_skid_dat  <= w_skid_dat_next;
            r_skid_addr <= w_skid_addr_next;
            r_ack_q     <= ldr_ack;
            r_dl_q      <= ioctl_download;
        end
    end

    assign ioctl_wait = r_wait;
    assign ldr_aen    = r_aen;
    assign ldr_addr   = r_addr;
    assign ldr_wdat   = r_wdat;
    assign ldr_be     = r_be;
    assign ldr_wr     = r_wr;
    assign ldr_done   = r_done;
    assign ldr_ovf    = r_ovf;

endmodule

// File: tb/tb_x68_ioctl_loader_bridge.sv
// Directed bench for x68_ioctl_loader_bridge with DW=16, NCH=2, IDX_BASE=0.
module tb_x68_ioctl_loader_bridge;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [1:0]  ldr_aen;
    logic [19:0] ldr_addr;
    logic [15:0] ldr_wdat;
    logic [1:0]  ldr_be;
    logic        ldr_wr;
    logic        ldr_ack;
    logic [1:0]  ldr_done;
    logic        ldr_ovf;

    int n_checks = 0;
    int n_errors = 0;

    x68_ioctl_loader_bridge #(.DW(16), .AW(20), .NCH(2), .IDX_BASE(0)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .ldr_aen(ldr_aen), .ldr_addr(ldr_addr),
        .ldr_wdat(ldr_wdat), .ldr_be(ldr_be), .ldr_wr(ldr_wr),
        .ldr_ack(ldr_ack), .ldr_done(ldr_done), .ldr_ovf(ldr_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    // Wait for a request, check it, hold it two cycles, then acknowledge
    task automatic do_req(input string tag, input logic [19:0] a,
                          input logic [15:0] w, input logic [1:0] b);
        int n = 0;
        while (!ldr_wr && n < 16) begin
            tick();
            n++;
        end
        check({tag, ".wr"},   {31'd0, ldr_wr}, 32'd1);
        check({tag, ".addr"}, {12'd0, ldr_addr}, {12'd0, a});
        check({tag, ".wdat"}, {16'd0, ldr_wdat}, {16'd0, w});
        check({tag, ".be"},   {30'd0, ldr_be}, {30'd0, b});
        check({tag, ".wait"}, {31'd0, ioctl_wait}, 32'd1);
        tick();
        tick();
        check({tag, ".hold"}, {15'd0, ldr_wr, ldr_wdat}, {15'd0, 1'b1, w});
        ldr_ack = 1'b1;
        tick();
        check({tag, ".wr_drop"},   {31'd0, ldr_wr}, 32'd0);
        check({tag, ".wait_drop"}, {31'd0, ioctl_wait}, 32'd0);
        ldr_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ldr_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset.outs", {ioctl_wait, ldr_aen, ldr_wr, ldr_done, ldr_ovf, ldr_be}, 32'd0);
        check("reset.data", {12'd0, ldr_addr}, 32'd0);

        // Channel 0, four bytes, two full words
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        tick();
        check("ch0.aen", {30'd0, ldr_aen}, 32'd1);
        send_byte(25'd0, 8'h11);
        check("ch0.no_wr_yet", {31'd0, ldr_wr}, 32'd0);
        send_byte(25'd1, 8'h22);
        check("ch0.latency", {31'd0, ldr_wr}, 32'd1);
        do_req("ch0.w0", 20'd0, 16'h1122, 2'b11);
        send_byte(25'd2, 8'h33);
        send_byte(25'd3, 8'h44);
        do_req("ch0.w1", 20'd1, 16'h3344, 2'b11);
        ioctl_download = 1'b0;
        tick();
        check("ch0.fini_aen", {30'd0, ldr_aen}, 32'd1);
        tick();
        check("ch0.done", {30'd0, ldr_done}, 32'd1);
        check("ch0.aen_off", {30'd0, ldr_aen}, 32'd0);

        // Channel 1, odd length: tail word issued after the window closes
        ioctl_index = 8'd1; ioctl_download = 1'b1;
        tick();
        check("ch1.aen", {30'd0, ldr_aen}, 32'd2);
        send_byte(25'd0, 8'hAA);
        send_byte(25'd1, 8'hBB);
        do_req("ch1.w0", 20'd0, 16'hAABB, 2'b11);
        send_byte(25'd2, 8'hCC);
        ioctl_download = 1'b0;
        tick();
        check("ch1.done_pending", {30'd0, ldr_done}, 32'd1);
        do_req("ch1.tail", 20'd1, 16'hCC00, 2'b10);
        tick();
        check("ch1.done", {30'd0, ldr_done}, 32'd3);

        // Out-of-range index and a repeat to a finished channel are ignored
        for (int k = 0; k < 2; k++) begin
            ioctl_index = (k == 0) ? 8'd2 : 8'd0;
            ioctl_download = 1'b1;
            tick();
            check($sformatf("ign%0d.aen", k), {30'd0, ldr_aen}, 32'd0);
            send_byte(25'd0, 8'h12);
            send_byte(25'd1, 8'h34);
            tick();
            check($sformatf("ign%0d.wr_wait", k), {30'd0, ldr_wr, ioctl_wait}, 32'd0);
            ioctl_download = 1'b0;
            tick(); tick();
            check($sformatf("ign%0d.done", k), {30'd0, ldr_done}, 32'd3);
        end

        // Clear done flags, then stall on a permanently high ack
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2.done", {30'd0, ldr_done}, 32'd0);
        ldr_ack = 1'b1;
        tick();
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        tick();
        send_byte(25'd0, 8'h55);
        send_byte(25'd1, 8'h66);
        tick(); tick(); tick();
        check("stall.wr", {30'd0, ldr_wr, ioctl_wait}, 32'd3);
        check("stall.wdat", {16'd0, ldr_wdat}, 32'h5566);
        send_byte(25'd2, 8'h77);
        check("stall.ovf0", {31'd0, ldr_ovf}, 32'd0);
        send_byte(25'd3, 8'h88);
        check("stall.ovf1", {31'd0, ldr_ovf}, 32'd1);
        check("stall.still", {30'd0, ldr_wr, ioctl_wait}, 32'd3);

        // Reset while a request is outstanding
        reset = 1'b1; ioctl_download = 1'b0;
        tick();
        check("rst3.outs", {26'd0, ldr_wr, ldr_aen, ldr_done, ldr_ovf}, 32'd0);
        check("rst3.wait", {31'd0, ioctl_wait}, 32'd0);
        reset = 1'b0; ldr_ack = 1'b0;
        tick();

        // Fresh download loads from byte 0
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        tick();
        send_byte(25'd0, 8'h01);
        send_byte(25'd1, 8'h02);
        do_req("fresh.w0", 20'd0, 16'h0102, 2'b11);
        send_byte(25'd2, 8'h03);
        ioctl_download = 1'b0;
        do_req("fresh.tail", 20'd1, 16'h0300, 2'b10);
        tick();
        check("fresh.done", {30'd0, ldr_done}, 32'd1);

        // Address jump: partial word flushed, new byte replayed from skid
        ioctl_index = 8'd1; ioctl_download = 1'b1;
        tick();
        send_byte(25'd4, 8'h9A);
        send_byte(25'd6, 8'hBC);
        do_req("skid.flush", 20'd2, 16'h9A00, 2'b10);
        ioctl_download = 1'b0;
        do_req("skid.replay", 20'd3, 16'hBC00, 2'b10);
        tick();
        check("skid.done", {30'd0, ldr_done}, 32'd3);
        check("final.ovf", {31'd0, ldr_ovf}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
